two_bit_sequencer: RTL and testbench

//  Initiator for the two-bit computer's operand/opcode interface. Holds a small program of
//  {i1,i0,a1,a0,b1,b0} words. On start, issues each word to the computer, waits a settle

---
 rtl/two_bit_pkg.sv | 40 ++++
 rtl/two_bit_regfile.sv | 39 +++
 rtl/two_bit_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_two_bit_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_bit_pkg.sv
// Shared types and field positions for the two-bit computer sequencer.
package two_bit_pkg;

  // Run-control states of the sequencer
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Program word layout {i1,i0,a1,a0,b1,b0}
  localparam int INSTR_W = 6;
  localparam int I1      = 5;
  localparam int I0      = 4;
  localparam int A1      = 3;
  localparam int A0      = 2;
  localparam int B1      = 1;
  localparam int B0      = 0;

  // Result word layout {error,f1,f0}
  localparam int RES_W   = 3;
  localparam int RES_ERR = 2;
  localparam int RES_F1  = 1;
  localparam int RES_F0  = 0;

  // Assemble a result word from the computer's response lines
  function automatic logic [RES_W-1:0] pack_result(input logic err,
                                                   input logic f1,
                                                   input logic f0);
    logic [RES_W-1:0] v;
    v          = '0;
    v[RES_ERR] = err;
    v[RES_F1]  = f1;
    v[RES_F0]  = f0;
    return v;
  endfunction

endpackage : two_bit_pkg

// File: rtl/two_bit_regfile.sv
// Small register-file memory: one write port, one registered read port.
// A read of an address being written in the same cycle returns the old word.
module two_bit_regfile #(
  parameter int W  = 6,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  // Storage write; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port, cleared by reset, old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : two_bit_regfile

// File: rtl/two_bit_sequencer.sv
// Initiator for the two-bit computer: steps through a stored program, presents
// each word as operands/opcode, waits for the result to settle, records
// {error,f1,f0} per instruction and counts errors.
module two_bit_sequencer
  import two_bit_pkg::*;
#(
  parameter int AW            = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int HALT_ON_ERR   = 1,
  parameter int CW            = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [5:0]    prog_data,
  input  logic [AW-1:0] last_addr,
  input  logic          start,
  output logic          a1,
  output logic          a0,
  output logic          b1,
  output logic          b0,
  output logic          i1,
  output logic          i0,
  input  logic          f1,
  input  logic          f0,
  input  logic          error,
  output logic          busy,
  output logic          done,
  output logic          halted_err,
  output logic [CW-1:0] err_count,
  input  logic [AW-1:0] res_rd_addr,
  output logic [2:0]    res_rd_data
);

  localparam int            SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SET_END = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};
  localparam logic          HALT_EN = (HALT_ON_ERR != 0);

  state_e               r_state;
  logic [AW-1:0]        r_pc;
  logic [AW-1:0]        r_last_addr;
  logic [SW-1:0]        r_settle_cnt;
  logic [CW-1:0]        r_err_count;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_halted_err;
  logic [INSTR_W-1:0]   r_ops;

  logic                 w_prog_we;
  logic [AW-1:0]        w_prog_rd_addr;
  logic [INSTR_W-1:0]   w_prog_rd_data;
  logic                 w_res_we;
  logic [RES_W-1:0]     w_res_wdata;
  logic                 w_halt_now;
  logic                 w_last;

  // Program writes only land while nothing is running
  assign w_prog_we   = prog_we && (r_state == IDLE);
  assign w_halt_now  = error && HALT_EN;
  assign w_last      = (r_pc == r_last_addr);
  assign w_res_we    = (r_state == CAPTURE);
  assign w_res_wdata = pack_result(error, f1, f0);

  // Program read address tracks the pc value the next state will hold, so the
  // registered read already shows prog[pc] during ISSUE
  always_comb begin
    w_prog_rd_addr = r_pc;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_prog_rd_addr = '0;
        end else begin
          w_prog_rd_addr = r_pc;
        end
      end
      CAPTURE: begin
        if (!w_halt_now && !w_last) begin
          w_prog_rd_addr = r_pc + AW'(1);
        end else begin
          w_prog_rd_addr = r_pc;
        end
      end
      default: begin
        w_prog_rd_addr = r_pc;
      end
    endcase
  end

  two_bit_regfile #(
    .W  (INSTR_W),
    .AW (AW)
  ) u_prog (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_prog_we),
    .i_wr_addr (prog_addr),
    .i_wr_data (prog_data),
    .i_rd_addr (w_prog_rd_addr),
    .o_rd_data (w_prog_rd_data)
  );

  two_bit_regfile #(
    .W  (RES_W),
    .AW (AW)
  ) u_result (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_res_we),
    .i_wr_addr (r_pc),
    .i_wr_data (w_res_wdata),
    .i_rd_addr (res_rd_addr),
    .o_rd_data (res_rd_data)
  );

  // Run-control FSM with pc, settle counter, error count and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_last_addr  <= '0;
      r_settle_cnt <= '0;
      r_err_count  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_halted_err <= 1'b0;
      r_ops        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= ISSUE;
            r_pc         <= '0;
            r_err_count  <= '0;
            r_halted_err <= 1'b0;
            r_last_addr  <= last_addr;
            r_busy       <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_ops        <= w_prog_rd_data;
          r_settle_cnt <= '0;
          r_state      <= SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt == SET_END) begin
            r_settle_cnt <= '0;
            r_state      <= CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end
        CAPTURE: begin
          if (error && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + CW'(1);
          end
          if (w_halt_now) begin
            r_halted_err <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else if (w_last) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_pc    <= r_pc + AW'(1);
            r_state <= ISSUE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i1         = r_ops[I1];
  assign i0         = r_ops[I0];
  assign a1         = r_ops[A1];
  assign a0         = r_ops[A0];
  assign b1         = r_ops[B1];
  assign b0         = r_ops[B0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign halted_err = r_halted_err;
  assign err_count  = r_err_count;

endmodule : two_bit_sequencer

// File: tb/tb_two_bit_sequencer.sv
// Self-checking bench for two_bit_sequencer with a stub computer f={a1^b1,a0^b0}.
module tb_two_bit_sequencer;

  logic       clk = 1'b0;
  logic       reset;

  // Main instance: AW=3, SETTLE_CYCLES=1, HALT_ON_ERR=1, CW=4
  logic       prog_we, start, err_in;
  logic [2:0] prog_addr, last_addr, res_rd_addr;
  logic [5:0] prog_data;
  logic       a1, a0, b1, b0, i1, i0, busy, done, halted_err;
  logic [3:0] err_count;
  logic [2:0] res_rd_data;
  logic [5:0] ops;

  // Second instance: CW=3, HALT_ON_ERR=0
  logic       prog_we3, start3, err3;
  logic [2:0] prog_addr3, last_addr3, res_rd_addr3;
  logic [5:0] prog_data3;
  logic       a13, a03, b13, b03, i13, i03, busy3, done3, halted3;
  logic [2:0] err_count3;
  logic [2:0] res_rd_data3;

  int n_cmp = 0;
  int n_bad = 0;

  assign ops = {i1, i0, a1, a0, b1, b0};

  always #5 clk = ~clk;

  two_bit_sequencer dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .last_addr(last_addr), .start(start),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .i1(i1), .i0(i0),
    .f1(a1 ^ b1), .f0(a0 ^ b0), .error(err_in),
    .busy(busy), .done(done), .halted_err(halted_err), .err_count(err_count),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
  );

  two_bit_sequencer #(.AW(3), .SETTLE_CYCLES(1), .HALT_ON_ERR(0), .CW(3)) dut3 (
    .clk(clk), .reset(reset), .prog_we(prog_we3), .prog_addr(prog_addr3),
    .prog_data(prog_data3), .last_addr(last_addr3), .start(start3),
    .a1(a13), .a0(a03), .b1(b13), .b0(b03), .i1(i13), .i0(i03),
    .f1(a13 ^ b13), .f0(a03 ^ b03), .error(err3),
    .busy(busy3), .done(done3), .halted_err(halted3), .err_count(err_count3),
    .res_rd_addr(res_rd_addr3), .res_rd_data(res_rd_data3)
  );

  typedef struct packed {
    logic       start;
    logic       exp_busy;
    logic       exp_done;
    logic [5:0] exp_ops;
  } vec_t;

  vec_t run_tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read main-instance result word and compare one cycle later
  task automatic read_res(input logic [2:0] addr, input logic [2:0] exp, input string name);
    res_rd_addr = addr;
    @(posedge clk);
    @(negedge clk);
    chk(name, res_rd_data, exp);
    next_cycle();
  endtask

  // Apply the nominal three-instruction run, checked every cycle
  task automatic run_table(input string tag);
    for (int c = 0; c < 12; c++) begin
      start = run_tbl[c].start;
      @(negedge clk);
      chk($sformatf("%s_busy_c%0d", tag, c), busy, run_tbl[c].exp_busy);
      chk($sformatf("%s_done_c%0d", tag, c), done, run_tbl[c].exp_done);
      chk($sformatf("%s_ops_c%0d",  tag, c), ops,  run_tbl[c].exp_ops);
      if (c == 10) chk($sformatf("%s_errcnt", tag), err_count, 4'd0);
      next_cycle();
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   done_cnt;
    logic got;
    int   k_done;

    run_tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b000000};
    run_tbl[1]  = '{1'b0, 1'b1, 1'b0, 6'b000000};
    run_tbl[2]  = '{1'b0, 1'b1, 1'b0, 6'b000110};
    run_tbl[3]  = '{1'b0, 1'b1, 1'b0, 6'b000110};
    run_tbl[4]  = '{1'b0, 1'b1, 1'b0, 6'b000110};
    run_tbl[5]  = '{1'b0, 1'b1, 1'b0, 6'b011101};
    run_tbl[6]  = '{1'b0, 1'b1, 1'b0, 6'b011101};
    run_tbl[7]  = '{1'b0, 1'b1, 1'b0, 6'b011101};
    run_tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'b101010};
    run_tbl[9]  = '{1'b0, 1'b1, 1'b0, 6'b101010};
    run_tbl[10] = '{1'b0, 1'b0, 1'b1, 6'b101010};
    run_tbl[11] = '{1'b0, 1'b0, 1'b0, 6'b101010};

    reset = 1'b1; prog_we = 1'b0; start = 1'b0; err_in = 1'b0;
    prog_addr = 3'd0; prog_data = 6'd0; last_addr = 3'd2; res_rd_addr = 3'd0;
    prog_we3 = 1'b0; start3 = 1'b0; err3 = 1'b0;
    prog_addr3 = 3'd0; prog_data3 = 6'd0; last_addr3 = 3'd7; res_rd_addr3 = 3'd0;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_halted", halted_err, 1'b0);
    chk("rst_errcnt", err_count, 4'd0);
    chk("rst_ops", ops, 6'd0);
    chk("rst_res", res_rd_data, 3'd0);
    next_cycle();

    // Load program
    prog_we = 1'b1;
    prog_addr = 3'd0; prog_data = 6'b000110; next_cycle();
    prog_addr = 3'd1; prog_data = 6'b011101; next_cycle();
    prog_addr = 3'd2; prog_data = 6'b101010; next_cycle();
    prog_we = 1'b0;
    next_cycle();

    // Test 1: nominal run
    run_table("t1");

    // Test 6: read latency on result port (addr was 0 so far)
    res_rd_addr = 3'd1;
    @(negedge clk);
    chk("t6_old_data", res_rd_data, 3'b011);
    next_cycle();
    @(negedge clk);
    chk("t6_new_data", res_rd_data, 3'b010);
    next_cycle();
    read_res(3'd0, 3'b011, "t1_res0");
    read_res(3'd2, 3'b000, "t1_res2");

    // Test 2: error on instr 1 capture, halt
    for (int c = 0; c < 13; c++) begin
      start  = (c == 0);
      err_in = (c >= 6 && c <= 10);
      @(negedge clk);
      chk($sformatf("t2_busy_c%0d", c), busy, (c >= 1 && c <= 6));
      chk($sformatf("t2_done_c%0d", c), done, (c == 7));
      next_cycle();
    end
    start = 1'b0; err_in = 1'b0;
    @(negedge clk);
    chk("t2_halted", halted_err, 1'b1);
    chk("t2_errcnt", err_count, 4'd1);
    next_cycle();
    read_res(3'd0, 3'b011, "t2_res0");
    read_res(3'd1, 3'b110, "t2_res1");
    read_res(3'd2, 3'b000, "t2_res2_unchanged");
    @(negedge clk);
    chk("t2_halted_sticky", halted_err, 1'b1);
    next_cycle();

    // Test 4: start and prog_we mid-run are ignored
    done_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      start     = (c == 0 || c == 4);
      prog_we   = (c == 4);
      prog_addr = 3'd0;
      prog_data = 6'b111111;
      @(negedge clk);
      if (c == 0) chk("t4_halted_before", halted_err, 1'b1);
      if (c == 1) chk("t4_halted_cleared", halted_err, 1'b0);
      chk($sformatf("t4_busy_c%0d", c), busy, (c >= 1 && c <= 9));
      chk($sformatf("t4_done_c%0d", c), done, (c == 10));
      if (done) done_cnt++;
      next_cycle();
    end
    start = 1'b0; prog_we = 1'b0;
    chk("t4_done_once", done_cnt, 1);
    chk("t4_errcnt", err_count, 4'd0);

    // Test 5: reset at first SETTLE of instr 1, then rerun
    for (int c = 0; c < 6; c++) begin
      start = (c == 0);
      reset = (c == 5);
      next_cycle();
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ops", ops, 6'd0);
    chk("t5_errcnt", err_count, 4'd0);
    chk("t5_done", done, 1'b0);
    chk("t5_res", res_rd_data, 3'd0);
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_nodone_%0d", c), done, 1'b0);
      chk($sformatf("t5_idle_%0d", c), busy, 1'b0);
      next_cycle();
    end
    run_table("t5");
    read_res(3'd0, 3'b011, "t5_res0_prog0_intact");
    read_res(3'd1, 3'b010, "t5_res1");
    read_res(3'd2, 3'b000, "t5_res2");

    // Test 3: saturating error count, no halt, full depth
    prog_we3 = 1'b1;
    for (int a = 0; a < 8; a++) begin
      prog_addr3 = 3'(a);
      prog_data3 = 6'(a * 5);
      next_cycle();
    end
    prog_we3 = 1'b0;
    err3 = 1'b1;
    start3 = 1'b1;
    next_cycle();
    start3 = 1'b0;
    got = 1'b0;
    k_done = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done3) begin
        got = 1'b1;
        k_done = k;
      end
      next_cycle();
      if (got) break;
    end
    chk("t3_done_seen", got, 1'b1);
    chk("t3_done_cycle", k_done, 24);
    err3 = 1'b0;
    @(negedge clk);
    chk("t3_errcnt_sat", err_count3, 3'd7);
    chk("t3_halted", halted3, 1'b0);
    next_cycle();
    for (int a = 0; a < 8; a++) begin
      res_rd_addr3 = 3'(a);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t3_res%0d_err", a), res_rd_data3[2], 1'b1);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_two_bit_sequencer
